fsm_mealy_moore: RTL and testbench
==================================

Name: fsm_mealy_moore

Overview:
Rising-edge detector on the single-bit input X, built twice in one block: once as a Mealy machine and once as a Moore machine. Q_mealy and Q_moore each pulse high for one clock cycle per 0->1 transition of X. The block is a teaching and reference unit, and the two outputs are cross-checked against each other in verification. Both machines share one clock and one reset, and their state registers are fully independent.

Parameters:
None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears both machines immediately
- X  input  1  monitored signal; changes on the falling edge of clk in normal use
- Q_mealy  output  1  Mealy edge pulse, combinational from state and X
- Q_moore  output  1  Moore edge pulse, decoded from state only (glitch-free, registered timing)

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - While reset=0, both machines are forced to their idle state: Mealy state S0, Moore state M_IDLE.
  - While reset=0, Q_mealy=0 and Q_moore=0 regardless of X or clk.
  - Release of reset is synchronised by the next rising clk edge; no other recovery is needed.
- Mealy machine: 2 states, S0 (last sampled X=0) and S1 (last sampled X=1).
  - Transitions at rising clk: next = S1 if X=1, else S0. The transition is the same from either state.
  - Output: Q_mealy = X AND (state==S0). It is purely combinational, so it follows X within the same cycle.
  - Latency: Q_mealy rises as soon as X rises while in S0, and is valid at the next rising edge. It falls when that edge moves the state to S1, or earlier if X drops.
  - Held X=1 gives Q_mealy=0 after the first edge. X=0 always gives Q_mealy=0.
- Moore machine: 3 states, M_IDLE (Q=0), M_RISE (Q=1), M_HIGH (Q=0).
  - M_IDLE: X=1 -> M_RISE; X=0 -> M_IDLE.
  - M_RISE: X=1 -> M_HIGH; X=0 -> M_IDLE.
  - M_HIGH: X=1 -> M_HIGH; X=0 -> M_IDLE.
  - Output: Q_moore=1 only in M_RISE, decoded from the state register only. It never depends combinationally on X.
  - Latency: Q_moore is high for exactly one full clock period. That period starts at the rising edge that samples the first X=1 after an X=0 (or after reset).
- Alignment between the outputs:
  - Both outputs produce one pulse per sampled rising edge of X.
  - The Mealy pulse is the cycle before the capturing edge; the Moore pulse is the cycle after it.
  - Therefore Q_mealy sampled just before a rising edge equals Q_moore sampled just after that edge.
- Boundary conditions:
  - X=1 at reset release: the first rising edge is treated as a rise. Q_moore pulses after it; Q_mealy is 1 before it.
  - Single-cycle X pulse (1 then 0): both machines emit one pulse. Moore goes M_RISE -> M_IDLE.
  - Alternating X every cycle: a pulse on every second cycle from each machine; Moore never reaches M_HIGH.
  - Reset asserted mid-pulse: both outputs drop to 0 immediately, with no pulse on release unless X rises afterwards per the rules above.
  - X glitches between clock edges affect Q_mealy combinationally but never Q_moore or either state.
- Implementation requirements:
  - Encoded state enums; separate next-state and output logic.
  - A default branch returns each machine to its idle state. Unreachable encodings (Moore code 2'b11) recover to M_IDLE on the next edge.

Test Plan:
- Reset: pulse reset low for 10 ps with X=0, then run one clock -> Q_mealy=0, Q_moore=0, and both machines are idle.
- Rise: at a falling edge set X=1. Just before the next rising edge expect Q_mealy=1, Q_moore=0. Just after that edge expect Q_mealy=0, Q_moore=1.
- Hold: keep X=1 for 3 more cycles -> Q_mealy=0 and Q_moore=0 on every sample after the Moore pulse cycle.
- Fall: set X=0 at a falling edge -> Q_mealy=0, Q_moore=0 for all subsequent cycles; both machines return to idle.
- Toggle and cross-check: X sequence 0,1,0,1,1,0,1 on falling edges. Expect 3 pulses on each output, and Q_mealy before edge n equals Q_moore after edge n on every cycle.
- Async reset mid-pulse: assert reset=0 midway through the Q_moore=1 cycle -> both outputs 0 within the same timestep. Release with X=1 held, and the first edge yields a fresh rise pulse.

Source files
------------

// File: rtl/fsm_mealy_moore.sv
// -----------------------------------------------------------------------------
// fsm_mealy_moore
//
// Rising-edge detector on X, implemented twice in one block so that the two
// classic FSM styles can be compared side by side:
//
//   * Mealy machine (2 states).
//     - The pulse is combinational from the state and X.
//     - Q_mealy is high in the cycle *before* the rising clock edge that
//       samples the new X=1.
//
//   * Moore machine (3 states).
//     - The pulse comes from a register and depends on the state only.
//     - Q_moore is high for the full cycle *after* that same edge.
//
// Consequently, Q_mealy sampled just before an edge equals Q_moore sampled
// just after it. The two machines share clk and reset but have completely
// independent state registers.
//
// Ports:
//   clk      in   system clock, all state updates on the rising edge
//   reset    in   asynchronous active-low reset, clears both machines
//   X        in   monitored signal (normally changes on the falling clk edge)
//   Q_mealy  out  Mealy edge pulse, combinational from state and X
//   Q_moore  out  Moore edge pulse, registered, high only in M_RISE
// -----------------------------------------------------------------------------
module fsm_mealy_moore (
   input  logic clk,
   input  logic reset,
   input  logic X,
   output logic Q_mealy,
   output logic Q_moore
);

   // --------------------------------------------------------------------------
   // State encodings
   // --------------------------------------------------------------------------
   typedef enum logic {
      S0 = 1'b0,   // last sampled X was 0
      S1 = 1'b1    // last sampled X was 1
   } mealy_state_t;

   // 2'b11 is unused; it decodes through the default branch back to M_IDLE.
   typedef enum logic [1:0] {
      M_IDLE = 2'b00,
      M_RISE = 2'b01,
      M_HIGH = 2'b10
   } moore_state_t;

   mealy_state_t mealy_q, mealy_d;
   moore_state_t moore_q, moore_d;
   logic         q_moore_q, q_moore_d;

   // --------------------------------------------------------------------------
   // Mealy next-state logic: the state simply remembers the sampled X.
   // The case keeps the structure explicit and gives a recovery default.
   // --------------------------------------------------------------------------
   always_comb begin
      mealy_d = S0;
      case (mealy_q)
         S0:      mealy_d = X ? S1 : S0;
         S1:      mealy_d = X ? S1 : S0;
         default: mealy_d = S0;
      endcase
   end

   // --------------------------------------------------------------------------
   // Moore next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      moore_d = M_IDLE;
      case (moore_q)
         M_IDLE:  moore_d = X ? M_RISE : M_IDLE;
         M_RISE:  moore_d = X ? M_HIGH : M_IDLE;
         M_HIGH:  moore_d = X ? M_HIGH : M_IDLE;
         default: moore_d = M_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Moore output decode.
   // The decode uses the next state so that the output register always
   // equals (moore_q == M_RISE) without any X-dependent logic after the flop.
   // --------------------------------------------------------------------------
   always_comb begin
      q_moore_d = 1'b0;
      case (moore_d)
         M_RISE:  q_moore_d = 1'b1;
         default: q_moore_d = 1'b0;
      endcase
   end

   // --------------------------------------------------------------------------
   // State and registered-output flops
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mealy_q   <= S0;
         moore_q   <= M_IDLE;
         q_moore_q <= 1'b0;
      end else begin
         mealy_q   <= mealy_d;
         moore_q   <= moore_d;
         q_moore_q <= q_moore_d;
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   // The reset term keeps Q_mealy low while reset is held, even if X=1.
   // The state is S0 at that point, so without the term Q_mealy would
   // otherwise follow X during reset.
   assign Q_mealy = X & reset & (mealy_q == S0);
   assign Q_moore = q_moore_q;

endmodule

// File: tb/tb_fsm_mealy_moore.sv
`timescale 1ns/1ps
module tb_fsm_mealy_moore;

   logic clk;
   logic reset;
   logic X;
   logic Q_mealy;
   logic Q_moore;

   int n_cmp;
   int n_fail;

   fsm_mealy_moore dut (
      .clk     (clk),
      .reset   (reset),
      .X       (X),
      .Q_mealy (Q_mealy),
      .Q_moore (Q_moore)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One step:
   //   - drive x at the falling edge;
   //   - sample the outputs 1 ns before the rising edge ("pre");
   //   - sample them again 1 ns after the rising edge ("post").
   typedef struct {
      logic x;
      logic mealy_pre;
      logic moore_pre;
      logic mealy_post;
      logic moore_post;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic x, input logic a, input logic b,
                               input logic c, input logic d);
      vec_t v;
      v.x = x;
      v.mealy_pre = a;
      v.moore_pre = b;
      v.mealy_post = c;
      v.moore_post = d;
      return v;
   endfunction

   initial begin
      int mealy_pulses;
      int moore_pulses;
      n_cmp  = 0;
      n_fail = 0;
      mealy_pulses = 0;
      moore_pulses = 0;

      // Rise, hold x3, fall.
      vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[1]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Toggle sequence 0,1,0,1,1,0,1, plus a trailing 0.
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vecs[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      vecs[13] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // Reset: 10 ps low pulse with X=0, then one clock.
      reset = 1'b1;
      X     = 1'b0;
      #2;
      reset = 1'b0;
      #0.005;
      check("rst_mealy_during", Q_mealy, 1'b0);
      check("rst_moore_during", Q_moore, 1'b0);
      #0.005;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mealy_after", Q_mealy, 1'b0);
      check("rst_moore_after", Q_moore, 1'b0);

      // Table-driven vectors.
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         X = vecs[i].x;
         #4;
         check($sformatf("v%0d_mealy_pre", i), Q_mealy, vecs[i].mealy_pre);
         check($sformatf("v%0d_moore_pre", i), Q_moore, vecs[i].moore_pre);
         if (i >= 6 && i <= 12 && Q_mealy === 1'b1) mealy_pulses++;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_mealy_post", i), Q_mealy, vecs[i].mealy_post);
         check($sformatf("v%0d_moore_post", i), Q_moore, vecs[i].moore_post);
         if (i >= 6 && i <= 12 && Q_moore === 1'b1) moore_pulses++;
      end
      check_int("toggle_mealy_pulses", mealy_pulses, 3);
      check_int("toggle_moore_pulses", moore_pulses, 3);

      // Glitch on X between edges:
      //   - it shows on Q_mealy;
      //   - it must not show on Q_moore;
      //   - it must not move either state.
      @(negedge clk);
      X = 1'b0;
      #1;
      X = 1'b1;
      #0.5;
      check("glitch_mealy", Q_mealy, 1'b1);
      check("glitch_moore", Q_moore, 1'b0);
      #0.5;
      X = 1'b0;
      @(posedge clk);
      #1;
      check("glitch_moore_post", Q_moore, 1'b0);
      check("glitch_mealy_post", Q_mealy, 1'b0);

      // A real rise afterwards proves both machines stayed idle.
      @(negedge clk);
      X = 1'b1;
      #4;
      check("rise2_mealy_pre", Q_mealy, 1'b1);
      check("rise2_moore_pre", Q_moore, 1'b0);
      @(posedge clk);
      #1;
      check("rise2_moore_post", Q_moore, 1'b1);

      // Async reset in the middle of the Moore pulse, with X held at 1.
      #1;
      reset = 1'b0;
      #0.1;
      check("midrst_mealy", Q_mealy, 1'b0);
      check("midrst_moore", Q_moore, 1'b0);
      @(posedge clk);
      #1;
      check("midrst_hold_moore", Q_moore, 1'b0);
      check("midrst_hold_mealy", Q_mealy, 1'b0);

      // Release with X=1: the first edge is treated as a fresh rise.
      @(negedge clk);
      reset = 1'b1;
      #4;
      check("rel_mealy_pre", Q_mealy, 1'b1);
      check("rel_moore_pre", Q_moore, 1'b0);
      @(posedge clk);
      #1;
      check("rel_mealy_post", Q_mealy, 1'b0);
      check("rel_moore_post", Q_moore, 1'b1);
      @(posedge clk);
      #1;
      check("rel_moore_next", Q_moore, 1'b0);
      check("rel_mealy_next", Q_mealy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
